// File: rtl/lif_sched_pkg.sv
// Shared definitions for the LIF timestep scheduler: default widths, FSM
// state encoding and a reference LIF next-state function.
// Optional build macro: LIF_SAT_INTEGRATE_EN (saturating integration).
package lif_sched_pkg;

    localparam int LIF_V_W  = 16;
    localparam int LIF_TR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } lif_state_t;

    typedef struct packed {
        logic [LIF_V_W-1:0]  v;
        logic [LIF_TR_W-1:0] tr;
        logic                fire;
    } lif_next_t;

    // One LIF step for a single neuron at the default widths.
    function automatic lif_next_t lif_next(
        input logic [LIF_V_W-1:0]  v,
        input logic [LIF_TR_W-1:0] tr,
        input logic                spk,
        input logic [LIF_V_W-1:0]  w,
        input logic [LIF_V_W-1:0]  th,
        input logic [LIF_V_W-1:0]  leak,
        input logic [LIF_TR_W-1:0] tref
    );
        lif_next_t          res;
        logic [LIF_V_W-1:0] addend;
        logic [LIF_V_W-1:0] integ;
        logic [LIF_V_W-1:0] eff_leak;
        logic [LIF_V_W-1:0] leaked;
`ifdef LIF_SAT_INTEGRATE_EN
        logic [LIF_V_W:0]   sum;
`endif
        addend = spk ? w : '0;
`ifdef LIF_SAT_INTEGRATE_EN
        sum   = {1'b0, v} + {1'b0, addend};
        integ = sum[LIF_V_W] ? {LIF_V_W{1'b1}} : sum[LIF_V_W-1:0];
`else
        integ = v + addend;
`endif
        // Leak is clamped against the stored potential so V never goes below 0.
        eff_leak = (leak > v) ? v : leak;
        leaked   = integ - eff_leak;
        res.v    = leaked;
        res.tr   = tr;
        res.fire = 1'b0;
        if (tr != '0) begin
            res.tr = tr - 1'b1;
            res.v  = LIF_V_W'(1);
        end else if (leaked >= th) begin
            res.v    = LIF_V_W'(1);
            res.tr   = tref;
            res.fire = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF update datapath shared by all neurons of the sweep.
// Optional build macro: LIF_SAT_INTEGRATE_EN makes integration saturate
// at all-ones instead of wrapping.
module lif_update_core
    import lif_sched_pkg::*;
#(
    parameter int V_W  = LIF_V_W,
    parameter int TR_W = LIF_TR_W
) (
    input  logic [V_W-1:0]  i_v,
    input  logic [TR_W-1:0] i_tr,
    input  logic            i_spk,
    input  logic [V_W-1:0]  i_w,
    input  logic [V_W-1:0]  i_th,
    input  logic [V_W-1:0]  i_leak,
    input  logic [TR_W-1:0] i_tref,
    output logic [V_W-1:0]  o_v,
    output logic [TR_W-1:0] o_tr,
    output logic            o_fire
);

    logic [V_W-1:0] w_addend;
    logic [V_W-1:0] w_integ;
    logic [V_W-1:0] w_eff_leak;
    logic [V_W-1:0] w_leaked;

    assign w_addend = i_spk ? i_w : '0;

`ifdef LIF_SAT_INTEGRATE_EN
    logic [V_W:0] w_sum;
    assign w_sum   = {1'b0, i_v} + {1'b0, w_addend};
    assign w_integ = w_sum[V_W] ? {V_W{1'b1}} : w_sum[V_W-1:0];
`else
    assign w_integ = i_v + w_addend;
`endif

    // Leak compares against the stored potential, not the integrated value.
    assign w_eff_leak = (i_leak > i_v) ? i_v : i_leak;
    assign w_leaked   = w_integ - w_eff_leak;

    // Refractory hold has priority over firing; firing resets V to 1.
    always_comb begin
        o_v    = w_leaked;
        o_tr   = i_tr;
        o_fire = 1'b0;
        if (i_tr != '0) begin
            o_tr = i_tr - 1'b1;
            o_v  = V_W'(1);
        end else if (w_leaked >= i_th) begin
            o_v    = V_W'(1);
            o_tr   = i_tref;
            o_fire = 1'b1;
        end
    end

endmodule

// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed LIF sequencer: on each accepted start it sweeps all
// neurons through one shared update core, emitting spike events over a
// valid/ready port. Optional build macro: LIF_SAT_INTEGRATE_EN (passed
// through to the update core).
module lif_timestep_scheduler
    import lif_sched_pkg::*;
#(
    parameter int N_NEURONS = 16,
    parameter int IDX_W     = 4,
    parameter int V_W       = LIF_V_W,
    parameter int TR_W      = LIF_TR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N_NEURONS-1:0] spike_in_vec,
    input  logic [V_W-1:0]       threshold,
    input  logic [V_W-1:0]       leak_value,
    input  logic [TR_W-1:0]      tref,
    output logic [IDX_W-1:0]     w_addr,
    input  logic [V_W-1:0]       w_data,
    output logic                 spk_valid,
    input  logic                 spk_ready,
    output logic [IDX_W-1:0]     spk_idx,
    output logic                 busy,
    output logic                 done
);

    lif_state_t           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_busy;
    logic                 r_spk_valid;
    logic [IDX_W-1:0]     r_spk_idx;
    logic [N_NEURONS-1:0] r_spk_sh;
    logic [V_W-1:0]       r_th;
    logic [V_W-1:0]       r_leak;
    logic [TR_W-1:0]      r_tref;

    logic [V_W-1:0]       w_v_all  [N_NEURONS];
    logic [TR_W-1:0]      w_tr_all [N_NEURONS];
    logic [V_W-1:0]       w_cur_v;
    logic [TR_W-1:0]      w_cur_tr;
    logic                 w_cur_spk;
    logic [V_W-1:0]       w_next_v;
    logic [TR_W-1:0]      w_next_tr;
    logic                 w_fire;
    logic                 w_wr_en;
    logic                 w_last;

    // The weight address simply follows the neuron pointer; memory returns
    // the word one cycle later, which is the UPDATE cycle.
    assign w_addr    = r_idx;
    assign spk_valid = r_spk_valid;
    assign spk_idx   = r_spk_idx;
    assign busy      = r_busy;
    assign done      = (r_state == ST_DONE);

    assign w_cur_v   = w_v_all[r_idx];
    assign w_cur_tr  = w_tr_all[r_idx];
    assign w_cur_spk = r_spk_sh[r_idx];
    assign w_wr_en   = (r_state == ST_UPDATE);
    assign w_last    = (r_idx == IDX_W'(N_NEURONS - 1));

    lif_update_core #(
        .V_W  (V_W),
        .TR_W (TR_W)
    ) u_core (
        .i_v    (w_cur_v),
        .i_tr   (w_cur_tr),
        .i_spk  (w_cur_spk),
        .i_w    (w_data),
        .i_th   (r_th),
        .i_leak (r_leak),
        .i_tref (r_tref),
        .o_v    (w_next_v),
        .o_tr   (w_next_tr),
        .o_fire (w_fire)
    );

    // Per-neuron state cells; only the selected neuron is written in UPDATE.
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : gen_neuron
        logic [V_W-1:0]  r_v;
        logic [TR_W-1:0] r_tr;
        logic            w_sel;

        assign w_sel        = w_wr_en && (r_idx == IDX_W'(gi));
        assign w_v_all[gi]  = r_v;
        assign w_tr_all[gi] = r_tr;

        // Write back the LIF result for this neuron when it is being updated.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_v  <= '0;
                r_tr <= '0;
            end else if (w_sel) begin
                r_v  <= w_next_v;
                r_tr <= w_next_tr;
            end
        end
    end

    // Sweep sequencer: capture, fetch/update each neuron, stall on emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_spk_valid <= 1'b0;
            r_spk_idx   <= '0;
            r_spk_sh    <= '0;
            r_th        <= '0;
            r_leak      <= '0;
            r_tref      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_spk_sh <= spike_in_vec;
                        r_th     <= threshold;
                        r_leak   <= leak_value;
                        r_tref   <= tref;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (w_fire) begin
                        r_spk_valid <= 1'b1;
                        r_spk_idx   <= r_idx;
                        r_state     <= ST_EMIT;
                    end else if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ST_FETCH;
                    end
                end
                ST_EMIT: begin
                    // Event and pointer stay frozen until the router accepts.
                    if (spk_ready) begin
                        r_spk_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Self-checking bench for lif_timestep_scheduler: table of timesteps with
// hand-derived spike masks and sweep lengths, a reference model feeding a
// spike scoreboard, and hand-written reset / start-ignore sequences.
module tb_lif_timestep_scheduler;
    import lif_sched_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] spike_in_vec;
    logic [15:0] threshold;
    logic [15:0] leak_value;
    logic [7:0]  tref;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic        spk_valid;
    logic        spk_ready;
    logic [3:0]  spk_idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    lif_timestep_scheduler #(
        .N_NEURONS (N),
        .IDX_W     (4),
        .V_W       (16),
        .TR_W      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .spike_in_vec (spike_in_vec),
        .threshold    (threshold),
        .leak_value   (leak_value),
        .tref         (tref),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .spk_valid    (spk_valid),
        .spk_ready    (spk_ready),
        .spk_idx      (spk_idx),
        .busy         (busy),
        .done         (done)
    );

    // Weight memory with one-cycle registered read.
    logic [15:0] wmem [N];
    always @(posedge clk) w_data <= wmem[w_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model state and expected spike order.
    logic [15:0] mv  [N];
    logic [7:0]  mtr [N];
    int          exp_q [$];

    task automatic model_step(input logic [15:0] vec, input logic [15:0] th,
                              input logic [15:0] lk, input logic [7:0] tr, input logic [15:0] w);
        logic [16:0] sum;
        logic [15:0] integ;
        logic [15:0] eff;
        logic [15:0] lv;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, mv[i]} + {1'b0, (vec[i] ? w : 16'h0)};
`ifdef LIF_SAT_INTEGRATE_EN
            integ = sum[16] ? 16'hFFFF : sum[15:0];
`else
            integ = sum[15:0];
`endif
            eff = (lk > mv[i]) ? mv[i] : lk;
            lv  = integ - eff;
            if (mtr[i] != 8'd0) begin
                mtr[i] = mtr[i] - 8'd1;
                mv[i]  = 16'd1;
            end else if (lv >= th) begin
                mv[i]  = 16'd1;
                mtr[i] = tr;
                exp_q.push_back(i);
            end else begin
                mv[i] = lv;
            end
        end
    endtask

    // Ready driver and spike scoreboard, both evaluated on the falling edge.
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    logic        hold_low  = 1'b0;
    logic        sb_en     = 1'b1;
    logic [3:0]  stall_idx = 4'd0;
    logic [15:0] obs_mask  = 16'h0;

    always @(negedge clk) begin
        if (spk_valid && !reset) begin
            if (hold_low) begin
                spk_ready = 1'b0;
            end else if (stall_cnt < stall_cfg) begin
                if (stall_cnt == 0) stall_idx = spk_idx;
                else chk("stall_spk_idx", 32'(spk_idx), 32'(stall_idx));
                chk("stall_idx_frozen", 32'(dut.r_idx), 32'(stall_idx));
                spk_ready = 1'b0;
                stall_cnt++;
            end else begin
                spk_ready = 1'b1;
                if (stall_cnt > 0) chk("stall_release_idx", 32'(spk_idx), 32'(stall_idx));
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_spike actual=%0d required=none", spk_idx);
                    end else begin
                        chk("sb_spk_idx", 32'(spk_idx), 32'(exp_q.pop_front()));
                    end
                    obs_mask[spk_idx] = 1'b1;
                end
                stall_cnt = 0;
            end
        end else begin
            spk_ready = 1'b1;
            stall_cnt = 0;
        end
    end

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (busy) cycles++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_v%0d", tag, i), 32'(dut.w_v_all[i]), 32'(mv[i]));
            chk($sformatf("%s_tr%0d", tag, i), 32'(dut.w_tr_all[i]), 32'(mtr[i]));
        end
    endtask

    task automatic run_ts(input string tag, input logic [15:0] vec, input logic [15:0] th,
                          input logic [15:0] lk, input logic [7:0] tr, input logic [15:0] w,
                          output int cycles);
        bit ok;
        for (int i = 0; i < N; i++) wmem[i] = w;
        model_step(vec, th, lk, tr, w);
        obs_mask = 16'h0;
        @(negedge clk);
        spike_in_vec = vec;
        threshold    = th;
        leak_value   = lk;
        tref         = tr;
        start        = 1'b1;
        @(negedge clk);
        // Scramble the captured inputs; the sweep must not see these.
        start        = 1'b0;
        spike_in_vec = ~vec;
        threshold    = 16'h0000;
        leak_value   = 16'hFFFF;
        tref         = 8'hFF;
        wait_done(cycles, ok);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_state(tag);
    endtask

    typedef struct {
        string       name;
        logic [15:0] vec;
        logic [15:0] w;
        logic [15:0] th;
        logic [15:0] leak;
        logic [7:0]  tref;
        int          stall;
        logic [15:0] exp_mask;
        int          exp_cycles;
    } ts_vec_t;

    ts_vec_t tbl [10];

    initial begin
        int        cyc;
        bit        ok;
        lif_next_t ln;

        reset        = 1'b1;
        start        = 1'b0;
        spike_in_vec = '0;
        threshold    = '0;
        leak_value   = '0;
        tref         = '0;
        spk_ready    = 1'b1;
        for (int i = 0; i < N; i++) begin
            wmem[i] = 16'h0;
            mv[i]   = 16'h0;
            mtr[i]  = 8'h0;
        end

        tbl[0] = '{"fire_n3",   16'h0008, 16'd150,  16'd100,  16'd0,  8'd2, 0, 16'h0008, 34};
        tbl[1] = '{"refr_1",    16'h0008, 16'd150,  16'd100,  16'd0,  8'd2, 0, 16'h0000, 33};
        tbl[2] = '{"refr_2",    16'h0008, 16'd150,  16'd100,  16'd0,  8'd2, 0, 16'h0000, 33};
        tbl[3] = '{"refire",    16'h0008, 16'd150,  16'd100,  16'd0,  8'd2, 0, 16'h0008, 34};
        tbl[4] = '{"clamp_set", 16'h0020, 16'd3,    16'd100,  16'd0,  8'd0, 0, 16'h0000, 33};
        tbl[5] = '{"clamp",     16'h0000, 16'd0,    16'd100,  16'd10, 8'd0, 0, 16'h0000, 33};
        tbl[6] = '{"th_zero",   16'h0000, 16'd0,    16'd0,    16'd0,  8'd0, 0, 16'hFFFF, 49};
        tbl[7] = '{"backpress", 16'h0001, 16'd200,  16'd100,  16'd5,  8'd0, 7, 16'h0001, 41};
        tbl[8] = '{"ovf_set",   16'h0004, 16'hFFF0, 16'hFFFF, 16'd0,  8'd0, 0, 16'h0000, 33};
`ifdef LIF_SAT_INTEGRATE_EN
        tbl[9] = '{"ovf",       16'h0004, 16'h0020, 16'hFFFF, 16'd0,  8'd0, 0, 16'h0004, 34};
`else
        tbl[9] = '{"ovf",       16'h0004, 16'h0020, 16'hFFFF, 16'd0,  8'd0, 0, 16'h0000, 33};
`endif

        repeat (3) @(negedge clk);
        chk("rst_spk_valid", 32'(spk_valid), 32'd0);
        chk("rst_spk_idx", 32'(spk_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        check_state("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Shared next-state function against hand-derived results.
        ln = lif_next(16'd0, 8'd0, 1'b1, 16'd150, 16'd100, 16'd0, 8'd2);
        chk("fn_fire_v", 32'(ln.v), 32'd1);
        chk("fn_fire_tr", 32'(ln.tr), 32'd2);
        chk("fn_fire_f", 32'(ln.fire), 32'd1);
        ln = lif_next(16'd5, 8'd2, 1'b1, 16'd100, 16'd0, 16'd0, 8'd3);
        chk("fn_refr_v", 32'(ln.v), 32'd1);
        chk("fn_refr_tr", 32'(ln.tr), 32'd1);
        chk("fn_refr_f", 32'(ln.fire), 32'd0);
        ln = lif_next(16'd3, 8'd0, 1'b0, 16'd0, 16'd100, 16'd10, 8'd0);
        chk("fn_clamp_v", 32'(ln.v), 32'd0);
        chk("fn_clamp_f", 32'(ln.fire), 32'd0);
        ln = lif_next(16'hFFF0, 8'd0, 1'b1, 16'h0020, 16'hFFFF, 16'd0, 8'd0);
`ifdef LIF_SAT_INTEGRATE_EN
        chk("fn_ovf_v", 32'(ln.v), 32'd1);
        chk("fn_ovf_f", 32'(ln.fire), 32'd1);
`else
        chk("fn_ovf_v", 32'(ln.v), 32'h10);
        chk("fn_ovf_f", 32'(ln.fire), 32'd0);
`endif

        for (int t = 0; t < 10; t++) begin
            stall_cfg = tbl[t].stall;
            run_ts(tbl[t].name, tbl[t].vec, tbl[t].th, tbl[t].leak, tbl[t].tref, tbl[t].w, cyc);
            chk({tbl[t].name, "_cycles"}, 32'(cyc), 32'(tbl[t].exp_cycles));
            chk({tbl[t].name, "_mask"}, 32'(obs_mask), 32'(tbl[t].exp_mask));
            $display("timestep %s cycles=%0d spikes=0x%04h", tbl[t].name, cyc, obs_mask);
        end
        stall_cfg = 0;

        // Reset while an event is stalled in EMIT.
        hold_low = 1'b1;
        sb_en    = 1'b0;
        @(negedge clk);
        spike_in_vec = 16'h0;
        threshold    = 16'h0;
        leak_value   = 16'h0;
        tref         = 8'd3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (spk_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rme_reached_emit", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        chk("rme_still_valid", 32'(spk_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rme_spk_valid", 32'(spk_valid), 32'd0);
        chk("rme_busy", 32'(busy), 32'd0);
        chk("rme_done", 32'(done), 32'd0);
        for (int i = 0; i < N; i++) begin
            mv[i]  = 16'h0;
            mtr[i] = 8'h0;
        end
        check_state("rme");
        hold_low = 1'b0;
        sb_en    = 1'b1;
        exp_q.delete();
        $display("sequence reset_mid_emit done");

        // Start while busy and start during DONE are both ignored.
        for (int i = 0; i < N; i++) wmem[i] = 16'h0;
        @(negedge clk);
        spike_in_vec = 16'h0;
        threshold    = 16'hFFFF;
        leak_value   = 16'h0;
        tref         = 8'd0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        ok    = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (busy) cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            start = (k == 5);
            if (k == 5) threshold = 16'h0;
            @(negedge clk);
            start = 1'b0;
        end
        chk("sib_done_seen", 32'(ok), 32'd1);
        chk("sib_cycles", 32'(cyc), 32'd33);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sid_busy", 32'(busy), 32'd0);
        chk("sid_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("sid_busy2", 32'(busy), 32'd0);
        chk("sid_done2", 32'(done), 32'd0);
        check_state("sib");
        $display("sequence start_ignore cycles=%0d", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lif_timestep_scheduler.md
Name: lif_timestep_scheduler

Overview:
- Time-multiplexed sequencer that shares one leaky-integrate-and-fire update datapath across N_NEURONS neurons.
- Per-neuron membrane potential and refractory counter live in internal register arrays.
- On each timestep `start`, it walks neurons 0..N_NEURONS-1. For each neuron it fetches the synaptic weight, applies the LIF update, writes the state back, and emits a spike event over a valid/ready port.
- Sits between the timestep generator / weight memory and the spike router of the integer SNN.

Parameters:
- N_NEURONS, 16, number of neurons scheduled per timestep (>=2)
- IDX_W, 4, neuron index width; must equal clog2(N_NEURONS)
- V_W, 16, membrane potential / weight / threshold / leak width
- TR_W, 8, refractory counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  timestep tick; accepted only in IDLE
- spike_in_vec  in  N_NEURONS  input spike per neuron; captured on accepted start
- threshold  in  V_W  fire threshold; captured on accepted start
- leak_value  in  V_W  leak per timestep; captured on accepted start
- tref  in  TR_W  refractory length; captured on accepted start
- w_addr  out  IDX_W  weight memory address (current neuron)
- w_data  in  V_W  weight; valid exactly 1 cycle after w_addr is presented
- spk_valid  out  1  spike event valid
- spk_ready  in  1  downstream accepts event
- spk_idx  out  IDX_W  index of firing neuron
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the timestep sweep completes

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE; all V[i]=0; all TR[i]=0; idx=0.
  - spk_valid=0, spk_idx=0, busy=0, done=0, w_addr=0.
- FSM states: IDLE, FETCH, UPDATE, EMIT, DONE.
- IDLE:
  - start=1 captures spike_in_vec, threshold, leak_value and tref into shadow registers.
  - Sets idx=0 and busy=1, then goes to FETCH.
  - Inputs changing after capture have no effect until the next accepted start.
- FETCH:
  - Drives w_addr=idx, then goes to UPDATE.
- UPDATE: w_data is valid this cycle. Compute:
  - integ = V[idx] + (spk_shadow[idx] ? w_data : 0), computed at V_W+1 bits and truncated to V_W (wrap).
  - eff_leak = (leak > V[idx]) ? V[idx] : leak.
  - leaked = integ - eff_leak.
- UPDATE outcomes:
  - If TR[idx]>0: TR[idx]-=1, V[idx]=1, no spike.
  - Else if leaked >= threshold: V[idx]=1, TR[idx]=tref, spk_idx=idx, spk_valid=1, go to EMIT.
  - Else: V[idx]=leaked.
- Advance rule after a non-spiking UPDATE:
  - If idx==N_NEURONS-1, go to DONE.
  - Otherwise idx+=1 and go to FETCH.
- EMIT:
  - spk_valid and spk_idx are held stable until the cycle spk_valid&spk_ready.
  - In that cycle spk_valid drops next cycle, and idx advances or the FSM goes to DONE, exactly as after UPDATE.
  - There is no timeout; back-pressure stalls the sweep indefinitely.
- DONE:
  - done=1 for one cycle, busy=0 next cycle, then IDLE.
  - start during DONE is ignored.
- start while busy: ignored and not queued.
- Latency:
  - 2 cycles per non-firing neuron.
  - 2 cycles plus ready-wait cycles (>=1) per firing neuron.
  - Plus 1 DONE cycle.
  - Minimum sweep is 2*N_NEURONS+1 cycles from the accepted start to the done pulse.
- Boundaries:
  - threshold=0 fires every non-refractory neuron.
  - tref=0 means no refractory hold.
  - Leak never underflows V below 0, but integ wraps on overflow.
  - reset mid-sweep or mid-EMIT aborts immediately: spk_valid=0 and all state is cleared.

Optional Feature:
- Macro: LIF_SAT_INTEGRATE_EN.
- Defined: integ saturates at 2^V_W-1 when the V_W+1-bit sum overflows.
- Undefined: integ wraps modulo 2^V_W.
- All other behaviour is identical in both builds.

Decomposition:
- Package lif_sched_pkg holds:
  - FSM state enum typedef.
  - Default widths V_W and TR_W.
  - A function computing the LIF next-state (V, TR, fire) from (V, TR, spk, w, th, leak, tref), shared by the RTL and the bench reference model.
- One natural sub-module: lif_update_core, purely combinational. It implements the UPDATE arithmetic, including the saturation macro.

Test Plan:
- Single spike fires: N=16, th=100, leak=0, tref=2, neuron 3 spiking with w=150 → one event spk_idx=3, V[3]=1, TR[3]=2, done after 2*16+1+1 cycles (ready tied high).
- Refractory hold: repeat the same stimulus for the next two timesteps → no neuron-3 events, TR[3] goes 1 then 0, V[3]=1. Third timestep fires again.
- Leak clamp: V[5]=3, leak=10, no spike → V[5]=0 (no underflow).
- Back-pressure: spk_ready low for 7 cycles while neuron 0 fires → spk_valid/spk_idx=0 stable, idx does not advance, sweep completes after ready rises.
- Overflow: V=0xFFF0, w=0x0020, th=0xFFFF → without LIF_SAT_INTEGRATE_EN integ=0x0010 and no fire; with it integ=0xFFFF and fire.
- Reset mid-EMIT: assert reset during EMIT → next cycle spk_valid=0, busy=0, all V/TR=0; start while busy is ignored (done count unchanged).
